// File: rtl/backoff_pkg.sv
`default_nettype none
// backoff_pkg -- shared types, constants and helpers for the random-backoff engine. rev 1.0
package backoff_pkg;

   localparam int          SLOT_W         = 10;
   localparam logic [15:0] LFSR_POLY      = 16'hB400;
   localparam int          CW_EXP_ABS_MAX = 10;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DRAW   = 3'd1,
      S_COUNT  = 3'd2,
      S_FROZEN = 3'd3,
      S_DONE   = 3'd4
   } state_e;

   function automatic logic [3:0] clamp_exp(input logic [3:0] cw, input int lim);
      if (int'(cw) > lim) begin
         return 4'(lim);
      end
      return cw;
   endfunction

   function automatic logic [SLOT_W-1:0] slot_mask(input logic [3:0] e);
      logic [SLOT_W:0] m;
      m = ((SLOT_W+1)'(1) << e) - (SLOT_W+1)'(1);
      return m[SLOT_W-1:0];
   endfunction

   // Right-shifting Galois step; the polynomial taps land on bits 15,13,12,10.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? LFSR_POLY : 16'h0000);
   endfunction

endpackage
`default_nettype wire

// File: rtl/backoff_slot_counter_if.sv
`default_nettype none
// backoff_slot_counter_if -- control/status bundle between TX control FSM and backoff engine. rev 1.0
interface backoff_slot_counter_if;
   import backoff_pkg::*;

   logic [3:0]        cw_exp;
   logic              backoff_start;
   logic              ch_idle;
   logic              backoff_abort;
   logic              backoff_busy;
   logic              backoff_done;
   logic [SLOT_W-1:0] slots_drawn;
   logic [SLOT_W-1:0] slots_left;

   modport master (
      output cw_exp, backoff_start, ch_idle, backoff_abort,
      input  backoff_busy, backoff_done, slots_drawn, slots_left
   );

   modport slave (
      input  cw_exp, backoff_start, ch_idle, backoff_abort,
      output backoff_busy, backoff_done, slots_drawn, slots_left
   );

endinterface
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// lfsr16 -- free-running 16-bit Galois LFSR that reloads its seed rather than ever holding zero. rev 1.0
module lfsr16
   import backoff_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] q
);

   logic [15:0] q_q;
   logic [15:0] q_d;

   always_comb begin
      q_d = lfsr_next(q_q);
      if (q_d == 16'h0000) begin
         q_d = SEED;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= SEED;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/backoff_slot_counter.sv
`default_nettype none
// backoff_slot_counter -- CSMA/CA random backoff: LFSR slot draw, idle-gated countdown, done pulse. rev 1.0
module backoff_slot_counter
   import backoff_pkg::*;
#(
   parameter int          CW_EXP_MAX  = 8,
   parameter int          SLOT_CYCLES = 900,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 rst,
   backoff_slot_counter_if.slave bus
);

   localparam int EXP_LIM = (CW_EXP_MAX > CW_EXP_ABS_MAX) ? CW_EXP_ABS_MAX : CW_EXP_MAX;
   localparam int TMR_W   = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SLOT_CYCLES - 1);

   state_e            state_q, state_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [SLOT_W-1:0] left_q, left_d;
   logic [SLOT_W-1:0] drawn_q, drawn_d;
   logic [3:0]        exp_q, exp_d;
   logic              done_q, done_d;

   logic [15:0]       lfsr;
   logic [5:0]        lfsr_hi_unused;
   logic [SLOT_W-1:0] draw;

   lfsr16 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk (clk),
      .rst (rst),
      .q   (lfsr)
   );

   assign lfsr_hi_unused = lfsr[15:SLOT_W];
   assign draw           = lfsr[SLOT_W-1:0] & slot_mask(exp_q);

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      left_d  = left_q;
      drawn_d = drawn_q;
      exp_d   = exp_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.backoff_start) begin
               exp_d   = clamp_exp(bus.cw_exp, EXP_LIM);
               timer_d = '0;
               state_d = S_DRAW;
            end
         end
         S_DRAW: begin
            drawn_d = draw;
            left_d  = draw;
            timer_d = '0;
            if (draw == '0) begin
               state_d = S_DONE;
            end else if (bus.ch_idle) begin
               state_d = S_COUNT;
            end else begin
               state_d = S_FROZEN;
            end
         end
         S_COUNT: begin
            // Busy discards the partial slot: the timer restarts from 0 on resume.
            if (!bus.ch_idle) begin
               timer_d = '0;
               state_d = S_FROZEN;
            end else if (timer_q == TMR_LAST) begin
               timer_d = '0;
               left_d  = left_q - SLOT_W'(1);
               if (left_q == SLOT_W'(1)) begin
                  state_d = S_DONE;
               end
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         S_FROZEN: begin
            if (bus.ch_idle) begin
               timer_d = '0;
               state_d = S_COUNT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (bus.backoff_abort) begin
         state_d = S_IDLE;
         timer_d = '0;
         left_d  = '0;
         drawn_d = drawn_q;
      end

      // The pulse is registered alongside the DONE state so an abort can still suppress it.
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         left_q  <= '0;
         drawn_q <= '0;
         exp_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         left_q  <= left_d;
         drawn_q <= drawn_d;
         exp_q   <= exp_d;
         done_q  <= done_d;
      end
   end

   assign bus.backoff_busy = (state_q != S_IDLE);
   assign bus.backoff_done = done_q;
   assign bus.slots_drawn  = drawn_q;
   assign bus.slots_left   = left_q;

endmodule
`default_nettype wire

// File: tb/tb_backoff_slot_counter.sv
`default_nettype none
// tb_backoff_slot_counter -- directed and randomized checks of the backoff engine against a reference LFSR and scoreboard.
module tb_backoff_slot_counter;

   localparam int          SC   = 4;
   localparam int          EMAX = 8;
   localparam logic [15:0] SEED = 16'hACE1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   backoff_slot_counter_if bif ();

   backoff_slot_counter #(
      .CW_EXP_MAX  (EMAX),
      .SLOT_CYCLES (SC),
      .LFSR_SEED   (SEED)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int sb[$];
   bit hit[16];
   logic [15:0] m_lfsr;

   function automatic logic [15:0] ref_next(input logic [15:0] s);
      logic [15:0] ns;
      ns = s >> 1;
      if (s[0]) begin
         ns[15] = ~ns[15];
         ns[13] = ~ns[13];
         ns[12] = ~ns[12];
         ns[10] = ~ns[10];
      end
      return ns;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) m_lfsr <= SEED;
      else     m_lfsr <= ref_next(m_lfsr);
   end

   function automatic int exp_draw(input logic [15:0] s, input int cw);
      int e;
      e = (cw > EMAX) ? EMAX : cw;
      return int'(s[9:0]) & ((1 << e) - 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic power_up();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   // Leaves the bench at #1 into the DRAW cycle (T+1) with the expected draw queued.
   task automatic start_bo(input int cw);
      @(posedge clk); #1;
      bif.cw_exp        = 4'(cw);
      bif.backoff_start = 1'b1;
      @(posedge clk); #1;
      bif.backoff_start = 1'b0;
      sb.push_back(exp_draw(m_lfsr, cw));
   endtask

   task automatic finish_bo(input string tag, input int extra, input int poke_at,
                            input int off_at, input int off_len, output int n);
      int lat;
      lat = -1;
      n = sb.pop_front();
      @(posedge clk); #1;
      chk({tag, "_drawn"}, bif.slots_drawn, n);
      chk({tag, "_left"},  bif.slots_left,  n);
      chk({tag, "_busy2"}, bif.backoff_busy, 1);
      for (int c = 2; c < 2 + SC * n + extra + 50; c++) begin
         if (c > 2) begin
            @(posedge clk); #1;
         end
         bif.ch_idle = !(off_len > 0 && c >= off_at && c < off_at + off_len);
         if (off_len > 0 && c >= off_at && c < off_at + off_len)
            chk({tag, "_hold"}, bif.slots_left, n - 1);
         if (poke_at > 0) begin
            bif.backoff_start = (c == poke_at);
            bif.cw_exp        = 4'd0;
         end
         if (bif.backoff_done === 1'b1) begin
            lat = c;
            break;
         end
      end
      bif.ch_idle       = 1'b1;
      bif.backoff_start = 1'b0;
      chk({tag, "_lat"}, lat, 2 + SC * n + extra);
      if (poke_at > 0) chk({tag, "_drawn_kept"}, bif.slots_drawn, n);
      @(posedge clk); #1;
      chk({tag, "_done_1cyc"}, bif.backoff_done, 0);
      chk({tag, "_busy_fall"}, bif.backoff_busy, 0);
   endtask

   initial begin
      int n;
      int first_n;
      int cnt;
      int pulses;
      bif.cw_exp        = 4'd0;
      bif.backoff_start = 1'b0;
      bif.ch_idle       = 1'b1;
      bif.backoff_abort = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",  bif.backoff_busy, 0);
      chk("rst_done",  bif.backoff_done, 0);
      chk("rst_drawn", bif.slots_drawn,  0);
      chk("rst_left",  bif.slots_left,   0);

      power_up();
      start_bo(8);
      finish_bo("first", 0, 0, 0, 0, first_n);

      @(posedge clk); #1;
      chk("cw0_busy_t0", bif.backoff_busy, 0);
      start_bo(0);
      chk("cw0_busy_t1", bif.backoff_busy, 1);
      finish_bo("cw0", 0, 0, 0, 0, n);

      for (int k = 0; k < 1000; k++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         start_bo(4);
         finish_bo("cw4", 0, 0, 0, 0, n);
         if (n < 16) hit[n] = 1'b1;
      end
      cnt = 0;
      for (int i = 0; i < 16; i++) cnt += int'(hit[i]);
      chk("cw4_coverage", cnt, 16);

      for (int k = 0; k < 30; k++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         start_bo(15);
         finish_bo("cw15", 0, 0, 0, 0, n);
         chk("cw15_le255", bif.slots_drawn <= 10'd255, 1);
      end

      // Busy from T+8 (timer at 2 of slot 2) for 10 cycles: 3 elapsed slot cycles are lost on top.
      for (int k = 0; k < 50; k++) begin
         start_bo(4);
         if (sb[0] >= 3) break;
         finish_bo("pre_freeze", 0, 0, 0, 0, n);
      end
      finish_bo("freeze", 13, 0, 8, 10, n);

      for (int k = 0; k < 50; k++) begin
         start_bo(4);
         if (sb[0] >= 2) break;
         finish_bo("pre_ign", 0, 0, 0, 0, n);
      end
      finish_bo("restart_ignored", 0, 4, 0, 0, n);

      for (int k = 0; k < 50; k++) begin
         start_bo(4);
         if (sb[0] >= 1) break;
         finish_bo("pre_abort", 0, 0, 0, 0, n);
      end
      n = sb.pop_front();
      @(posedge clk); #1;
      @(posedge clk); #1;
      bif.backoff_abort = 1'b1;
      @(posedge clk); #1;
      bif.backoff_abort = 1'b0;
      chk("abort_busy",  bif.backoff_busy, 0);
      chk("abort_left",  bif.slots_left,   0);
      chk("abort_drawn", bif.slots_drawn,  n);
      pulses = 0;
      for (int c = 0; c < SC * n + 5; c++) begin
         if (bif.backoff_done === 1'b1) pulses++;
         @(posedge clk); #1;
      end
      chk("abort_no_done", pulses, 0);

      for (int k = 0; k < 50; k++) begin
         start_bo(4);
         if (sb[0] >= 1) break;
         finish_bo("pre_abort2", 0, 0, 0, 0, n);
      end
      n = sb.pop_front();
      repeat (SC * n) @(posedge clk);
      #1;
      bif.backoff_abort = 1'b1;
      @(posedge clk); #1;
      bif.backoff_abort = 1'b0;
      chk("abort_last_done", bif.backoff_done, 0);
      chk("abort_last_busy", bif.backoff_busy, 0);
      chk("abort_last_left", bif.slots_left,   0);

      start_bo(0);
      void'(sb.pop_front());
      bif.backoff_abort = 1'b1;
      @(posedge clk); #1;
      bif.backoff_abort = 1'b0;
      chk("abort_draw0_done", bif.backoff_done, 0);
      chk("abort_draw0_busy", bif.backoff_busy, 0);

      for (int k = 0; k < 50; k++) begin
         start_bo(8);
         if (sb[0] >= 1) break;
         finish_bo("pre_rst", 0, 0, 0, 0, n);
      end
      void'(sb.pop_front());
      @(posedge clk); #1;
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("arst_busy",  bif.backoff_busy, 0);
      chk("arst_done",  bif.backoff_done, 0);
      chk("arst_drawn", bif.slots_drawn,  0);
      chk("arst_left",  bif.slots_left,   0);
      repeat (2) @(posedge clk);
      power_up();
      start_bo(8);
      finish_bo("after_rst", 0, 0, 0, 0, n);
      chk("after_rst_same_draw", bif.slots_drawn, first_n);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/backoff_slot_counter.md
# backoff_slot_counter

Random-backoff engine for the xpu CSMA/CA path. It reads the contention-window exponent `cw_exp` (0..CW_EXP_MAX) from the CW tracker and draws a uniform slot count in [0, 2^cw_exp − 1] from an internal LFSR. It then counts those slots down while the channel is idle, freezing on busy, and issues a one-cycle `backoff_done` pulse to the TX control FSM when the count reaches zero.

## Interface
- `CW_EXP_MAX`, 8: upper clamp on the exponent used for the draw; legal range 0..10.
- `SLOT_CYCLES`, 900: clk cycles per backoff slot (9 µs at 100 MHz); must be ≥ 2.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `clk`  in  1  block clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cw_exp`  in  4  current contention-window exponent; sampled only on an accepted `backoff_start`.
- `backoff_start`  in  1  single-cycle request to begin a backoff; accepted only in IDLE.
- `ch_idle`  in  1  level; 1 = medium idle (CCA clear, DIFS already satisfied upstream).
- `backoff_abort`  in  1  level/pulse; returns to IDLE from any state without a done pulse.
- `backoff_busy`  out  1  high in every state except IDLE.
- `backoff_done`  out  1  registered, high for exactly one cycle when the countdown completes.
- `slots_drawn`  out  10  slot count drawn for the current or last backoff; holds until the next draw.
- `slots_left`  out  10  remaining slots; decremented as each slot completes.

## Operation
- States: IDLE, DRAW, COUNT, FROZEN, DONE.
- Effective exponent: `e = min(cw_exp, CW_EXP_MAX)`, latched on accept. Values of `cw_exp` above 10 also clamp to `CW_EXP_MAX`.
- IDLE → DRAW on `backoff_start`. `backoff_start` in any other state is ignored.
- DRAW (always 1 cycle):
  - Draw: `slots_drawn = slots_left = lfsr[9:0] & ((1<<e) − 1)`.
  - If the draw is 0, go to DONE.
  - Otherwise go to COUNT if `ch_idle`, else FROZEN.
- COUNT:
  - The slot timer counts 0..SLOT_CYCLES−1.
  - At SLOT_CYCLES−1 with `ch_idle`: decrement `slots_left`. If the result is 0, go to DONE; otherwise restart the timer at 0.
  - If `ch_idle`=0 in any COUNT cycle: go to FROZEN and clear the timer. The partial slot is discarded and `slots_left` is unchanged.
- FROZEN: hold `slots_left`. When `ch_idle`=1, go to COUNT with the timer at 0.
- DONE: drive `backoff_done`=1 for one cycle, then go to IDLE.
- `backoff_abort` has priority over every transition, including the DONE pulse: the next state is IDLE, the timer is cleared, and `slots_left` is forced to 0. `slots_drawn` is held.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Free-running: advances every cycle regardless of state.
  - Never loads zero.

## Timing
- Reset values: state IDLE; `backoff_busy`=0, `backoff_done`=0, `slots_drawn`=0, `slots_left`=0; timer 0; LFSR=`LFSR_SEED`.
- Start accepted at cycle T: DRAW at T+1. Outputs `slots_drawn`/`slots_left` are valid from T+2.
- Zero draw: `backoff_done` high at T+2.
- N slots, channel continuously idle: `backoff_done` high at T+2+N·SLOT_CYCLES.
- Each busy interruption adds the busy duration plus the elapsed portion of the interrupted slot.
- `backoff_busy` rises at T+1 and falls in the cycle after the `backoff_done` pulse (or after an abort).
- `ch_idle` is sampled combinationally into next-state logic with no synchronizer. It must be in the `clk` domain.
- `rst` asserted mid-countdown: every output returns to its reset value asynchronously, and no done pulse is issued.
- Widths: slot count and `slots_left` are 10 bits. The timer is `$clog2(SLOT_CYCLES)` bits. Decrement never underflows because the DONE check precedes it.

## Structure
- Package `backoff_pkg`: state enum, `SLOT_W`=10, `LFSR_POLY`=16'hB400, `CW_EXP_ABS_MAX`=10.
- One sub-module `lfsr16`: ports clk, rst, seed parameter, q[15:0]; free-running.
- Top-level: FSM, slot timer, slot counter; targets roughly 150–250 lines.

## Test plan
- `cw_exp`=0, `backoff_start` at T, `ch_idle`=1 → `slots_drawn`=0, `backoff_done` at T+2, `backoff_busy` high only T+1..T+2.
- `cw_exp`=4, `SLOT_CYCLES`=4, idle → `slots_drawn` ≤ 15, done exactly at T+2+4·`slots_drawn`; across 1000 runs, every value 0..15 is hit.
- `cw_exp`=15, `CW_EXP_MAX`=8 → all draws ≤ 255.
- Draw N ≥ 3, drop `ch_idle` for 10 cycles mid-slot 2 → `slots_left` is frozen during the busy period; done is delayed by 10 plus the elapsed partial slot.
- `backoff_abort` in COUNT, and separately in the DONE cycle → no `backoff_done` pulse, IDLE next cycle, `slots_left`=0. A second `backoff_start` during COUNT is ignored.
- `rst` asserted mid-COUNT, asynchronously between edges → outputs reset immediately; the LFSR restarts from the seed, so the first draw after reset equals the first draw after power-up.
